// File: rtl/hz_pkg.sv
// rtl/hz_pkg.sv - shared codes and slot record for the pipeline hazard controller
package hz_pkg;

  // Stage at whose end a result becomes valid
  localparam logic [1:0] RDY_EX   = 2'b00;
  localparam logic [1:0] RDY_MEM1 = 2'b01;
  localparam logic [1:0] RDY_MEM2 = 2'b10;

  // Where a source operand is consumed
  localparam logic [1:0] USE_NONE = 2'b00;
  localparam logic [1:0] USE_ID   = 2'b01;
  localparam logic [1:0] USE_EX   = 2'b10;

  // EX operand selects (MUX4/MUX5)
  localparam logic [1:0] SEL_GPR  = 2'b00;
  localparam logic [1:0] SEL_EX   = 2'b01;
  localparam logic [1:0] SEL_MEM1 = 2'b10;
  localparam logic [1:0] SEL_MEM2 = 2'b11;

  // ID compare selects (MUX8/MUX9)
  localparam logic [1:0] CMP_GPR  = 2'b00;
  localparam logic [1:0] CMP_MEM1 = 2'b01;
  localparam logic [1:0] CMP_MEM2 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] waddr;
    logic [1:0] rdy;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hz_match.sv
// rtl/hz_match.sv - compares one scoreboard slot against one source register
module hz_match
  import hz_pkg::*;
(
  input  slot_t      slot,
  input  logic [4:0] raddr,
  output logic       match,
  output logic [1:0] rdy
);

  // $0 is hardwired, so a write to it never produces a hazard
  assign match = slot.valid && slot.wen && (slot.waddr == raddr) && (raddr != 5'd0);
  assign rdy   = slot.rdy;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard, forwarding selects, ID stall and mult/div busy counter
module hazard_ctrl
  import hz_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_rs_use,
  input  logic [1:0] id_rt_use,
  input  logic       id_wen,
  input  logic [4:0] id_waddr,
  input  logic [1:0] id_rdy,
  input  logic       id_md_start,
  input  logic       id_hilo_use,
  output logic       stall,
  output logic [1:0] mux4_sel,
  output logic [1:0] mux5_sel,
  output logic [1:0] mux8_sel,
  output logic [1:0] mux9_sel,
  output logic       md_busy
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LAT);

  slot_t         s_ex, s_mem1, s_mem2, s_wb;
  logic [4:0]    ex_rs, ex_rt;
  logic [1:0]    ex_rs_use, ex_rt_use;
  logic [CW-1:0] md_cnt;

  slot_t pipe [4];
  assign pipe[0] = s_ex;
  assign pipe[1] = s_mem1;
  assign pipe[2] = s_mem2;
  assign pipe[3] = s_wb;

  logic [3:0] id_rs_hit, id_rt_hit;
  logic [1:0] id_rs_rdy [4];
  logic [1:0] id_rt_rdy [4];
  logic [3:1] ex_rs_hit, ex_rt_hit;
  logic [1:0] ex_rs_rdy [1:3];
  logic [1:0] ex_rt_rdy [1:3];

  for (genvar i = 0; i < 4; i++) begin : g_id
    hz_match u_rs (.slot(pipe[i]), .raddr(id_rs), .match(id_rs_hit[i]), .rdy(id_rs_rdy[i]));
    hz_match u_rt (.slot(pipe[i]), .raddr(id_rt), .match(id_rt_hit[i]), .rdy(id_rt_rdy[i]));
  end

  // The EX operand never needs to look at itself, only at older slots
  for (genvar i = 1; i < 4; i++) begin : g_ex
    hz_match u_rs (.slot(pipe[i]), .raddr(ex_rs), .match(ex_rs_hit[i]), .rdy(ex_rs_rdy[i]));
    hz_match u_rt (.slot(pipe[i]), .raddr(ex_rt), .match(ex_rt_hit[i]), .rdy(ex_rt_rdy[i]));
  end

  function automatic logic [1:0] ex_sel(input logic [1:0] op_use, input logic [3:1] hit,
                                        input logic [1:0] rdy_mem1, input logic [1:0] rdy_mem2);
    if (op_use != USE_EX) return SEL_GPR;
    if (hit[1] && rdy_mem1 == RDY_EX) return SEL_EX;
    if (hit[2] && rdy_mem2 <= RDY_MEM1) return SEL_MEM1;
    if (hit[3]) return SEL_MEM2;
    return SEL_GPR;
  endfunction

  function automatic logic [1:0] id_sel(input logic [1:0] op_use, input logic [3:0] hit,
                                        input logic [1:0] rdy_mem2);
    if (op_use != USE_ID) return CMP_GPR;
    if (hit[2] && rdy_mem2 <= RDY_MEM1) return CMP_MEM1;
    if (hit[3]) return CMP_MEM2;
    return CMP_GPR;
  endfunction

  // Branch compares happen in ID, so they wait one stage longer than EX consumers
  function automatic logic op_stall(input logic [1:0] op_use, input logic [3:0] hit,
                                    input logic [1:0] rdy_ex, input logic [1:0] rdy_mem1,
                                    input logic [1:0] rdy_mem2);
    if (op_use == USE_ID)
      return hit[0] || hit[1] || (hit[2] && rdy_mem2 == RDY_MEM2);
    if (op_use == USE_EX)
      return (hit[0] && rdy_ex >= RDY_MEM1) || (hit[1] && rdy_mem1 == RDY_MEM2);
    return 1'b0;
  endfunction

  logic rs_stall, rt_stall, md_issue;

  always_comb begin
    rs_stall = op_stall(id_rs_use, id_rs_hit, id_rs_rdy[0], id_rs_rdy[1], id_rs_rdy[2]);
    rt_stall = op_stall(id_rt_use, id_rt_hit, id_rt_rdy[0], id_rt_rdy[1], id_rt_rdy[2]);
    stall    = id_valid && (rs_stall || rt_stall || (id_hilo_use && md_busy));
    mux4_sel = ex_sel(ex_rs_use, ex_rs_hit, ex_rs_rdy[1], ex_rs_rdy[2]);
    mux5_sel = ex_sel(ex_rt_use, ex_rt_hit, ex_rt_rdy[1], ex_rt_rdy[2]);
    mux8_sel = id_sel(id_rs_use, id_rs_hit, id_rs_rdy[2]);
    mux9_sel = id_sel(id_rt_use, id_rt_hit, id_rt_rdy[2]);
    md_busy  = (md_cnt != '0);
    md_issue = id_md_start && id_valid && !stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ex      <= SLOT_BUBBLE;
      s_mem1    <= SLOT_BUBBLE;
      s_mem2    <= SLOT_BUBBLE;
      s_wb      <= SLOT_BUBBLE;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_rs_use <= USE_NONE;
      ex_rt_use <= USE_NONE;
      md_cnt    <= '0;
    end else if (!hold) begin
      s_wb   <= s_mem2;
      s_mem2 <= s_mem1;
      s_mem1 <= flush ? SLOT_BUBBLE : s_ex;
      if (id_valid && !stall && !flush) begin
        s_ex      <= '{valid: 1'b1, wen: id_wen, waddr: id_waddr, rdy: id_rdy};
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_rs_use <= id_rs_use;
        ex_rt_use <= id_rt_use;
      end else begin
        // Clearing the uses keeps the EX selects at GPR behind a bubble
        s_ex      <= SLOT_BUBBLE;
        ex_rs_use <= USE_NONE;
        ex_rt_use <= USE_NONE;
      end
      if (md_issue)
        md_cnt <= MD_LOAD;
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core (ID, EX, MEM1, MEM2, WB). It keeps a scoreboard of in-flight register writers and drives four selects: the EX-stage operand forwarding selects (MUX4Sel/MUX5Sel) and the ID-stage branch-compare selects (MUX8Sel/MUX9Sel). It also generates the ID stall for load-use, branch-use and HI/LO busy hazards, and owns the multi-cycle mult/div busy counter.

## Interface
Parameters:
- MD_LAT, 32, cycles a mult/div occupies HI/LO after issue (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- hold  in  1  global pipeline freeze (memory wait); all state frozen
- flush  in  1  exception/eret flush; kills ID→EX transfer and EX, MEM1 slots
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers
- id_rs_use, id_rt_use  in  2 each  00 unused, 01 needed in ID (branch), 10 needed in EX
- id_wen  in  1  instruction writes GPR
- id_waddr  in  5  destination (MUX1 output)
- id_rdy  in  2  stage whose end makes the result valid: 00 EX, 01 MEM1, 10 MEM2 (loads)
- id_md_start  in  1  issues mult/div
- id_hilo_use  in  1  reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- stall  out  1  freeze PC/IF/ID, inject bubble into EX
- mux4_sel, mux5_sel  out  2  EX operand select: 00 GPR, 01 data_EX, 10 data_MEM1, 11 data_MEM2
- mux8_sel, mux9_sel  out  2  ID compare select: 00 GPR, 01 data_MEM1, 10 data_MEM2
- md_busy  out  1  mult/div counter non-zero

## Operation
- Slots S_EX, S_MEM1, S_MEM2, S_WB each hold {valid, wen, waddr, rdy}; S_EX also holds rs, rt, rs_use, rt_use.
- Bus sourcing: data_EX = result of instruction in MEM1; data_MEM1 = result of instruction in MEM2; data_MEM2 = result of instruction in WB.
- A slot "matches" register r when valid & wen & waddr==r & r!=0. Register 0 never forwards or stalls.
- EX selects (combinational from S_EX rs/rt, each operand independent, youngest wins): S_MEM1 match & rdy==EX → 01; else S_MEM2 match & rdy≤MEM1 → 10; else S_WB match → 11; else 00. An operand with use 00 or 01 forces 00.
- ID selects: S_MEM2 match & rdy≤MEM1 → 01; else S_WB match → 10; else 00. Operand use ≠01 forces 00.
- Stall, only when id_valid and operand use ≠00, any of the following:
  - use 01 (branch) and S_EX or S_MEM1 matches, or S_MEM2 matches with rdy==MEM2;
  - use 10 and S_EX matches with rdy≥MEM1, or S_MEM1 matches with rdy==MEM2;
  - id_hilo_use & md_busy.
- Advance (posedge, hold=0): S_WB←S_MEM2, S_MEM2←S_MEM1, S_MEM1←S_EX, S_EX←ID fields if id_valid & !stall & !flush, else bubble (valid=0).
- flush=1: S_MEM1 and S_EX load as bubbles; S_MEM2 and S_WB advance normally.
- MD counter: loads MD_LAT when id_md_start & id_valid & !stall & !flush & !hold; otherwise decrements toward 0 each cycle when hold=0. md_busy = counter≠0. A flush does not cancel a running mult/div.

## Timing
- Reset (rst_n=0 at a posedge): all slots invalid, counter 0. stall=0, md_busy=0, all sels 00 from the next cycle. Reset overrides hold and flush.
- All outputs are combinational from current state and ID inputs: zero-cycle latency. State updates at posedge only.
- hold=1: no slot or counter change. Outputs remain valid and track inputs.
- Load followed by a dependent ALU op: 2 stall cycles, then mux sel 11. Load followed by a dependent branch: 3 stall cycles, then sel 10.
- ALU op followed by a dependent branch: 2 stall cycles, then sel 01.
- Simultaneous stall and flush: flush wins for S_EX (bubble); stall remains asserted.

## Structure
- Shared package hz_pkg: rdy codes (RDY_EX/MEM1/MEM2), use codes, select code constants, and the slot struct typedef.
- One sub-module, hz_match: a slot-vs-register comparator returning match and rdy. It is instantiated per slot and per operand.

## Test plan
- ALU writing $5, then an ALU op reading $5 in EX → stall=0, mux4_sel=01. One op later → 10. Two later → 11.
- lw $8, then add using $8 → stall=1 for 2 cycles, bubble enters EX, then mux5_sel=11, no stall.
- ALU writing $3, then beq reading $3 in ID → stall 2 cycles, then mux8_sel=01. For a lw producer: 3 cycles, then 10.
- Writer with waddr=0 followed by a reader of $0 → stall=0, all sels 00.
- MD_LAT=4: mult then mfhi → md_busy high 4 cycles, stall high exactly while busy. Assert hold mid-run → counter frozen.
- flush while a lw sits in S_EX → dependent instruction sees no stall, sel 00. Assert rst_n=0 mid-stall → next cycle all outputs 0.
